// File: rtl/mii_frame_checker.sv
// Passive MII frame checker: delineates frames on a multi-lane MII stream,
// measures their length, classifies them as good or errored and keeps counts.
module mii_frame_checker #(
    parameter int NUM_LANES = 8,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 9600,
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_LANES-1:0] data_in,
    input  logic [NUM_LANES-1:0]   ctrl_in,
    input  logic                   valid_in,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [2:0]             err_code,
    output logic                   seq_err,
    output logic                   in_frame,
    output logic [LEN_W-1:0]       last_len,
    output logic [CNT_W-1:0]       ok_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LANES_LEN = LEN_W'(NUM_LANES);
    localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_LANES-1:0] START_CTRL = {{(NUM_LANES-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt_s;
    logic [LEN_W-1:0] len_r, len_nxt_s;
    logic             is_idle_s, is_start_s, is_data_s, is_term_s, match_s;
    logic [LEN_W-1:0] term_bytes_s, word_bytes_s, len_sum_s, pulse_len_s;
    logic             ok_s, err_s, seq_s;
    logic [2:0]       code_s;
    logic             frame_ok_r, frame_err_r, seq_err_r, in_frame_r;
    logic [2:0]       err_code_r;
    logic [LEN_W-1:0] last_len_r;
    logic [CNT_W-1:0] ok_cnt_r, err_cnt_r;

    // Word classification; at most one terminate position can match a word.
    always_comb begin
        is_idle_s    = (ctrl_in == {NUM_LANES{1'b1}});
        is_start_s   = (ctrl_in == START_CTRL) && (data_in[7:0] == 8'hFB);
        is_data_s    = (ctrl_in == {NUM_LANES{1'b0}});
        is_term_s    = 1'b0;
        term_bytes_s = '0;
        match_s      = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            is_idle_s = is_idle_s & (data_in[8*k +: 8] == 8'h07);
            match_s   = 1'b1;
            for (int j = 0; j < NUM_LANES; j++) begin
                match_s = match_s & ((j < k)  ? ~ctrl_in[j] :
                                     (j == k) ? (ctrl_in[j] & (data_in[8*j +: 8] == 8'hFD)) :
                                                (ctrl_in[j] & (data_in[8*j +: 8] == 8'h07)));
            end
            term_bytes_s = match_s ? LEN_W'(k) : term_bytes_s;
            is_term_s    = is_term_s | match_s;
        end
    end

    assign word_bytes_s = is_data_s ? LANES_LEN : (is_term_s ? term_bytes_s : '0);
    assign len_sum_s    = len_r + word_bytes_s;

    // Next-state, next-length and pulse decisions for the sampled word.
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        ok_s        = 1'b0;
        err_s       = 1'b0;
        seq_s       = 1'b0;
        code_s      = 3'd0;
        pulse_len_s = len_r;
        if (valid_in) begin
            case (state_r)
                S_IDLE: begin
                    if (is_start_s) begin
                        state_nxt_s = S_DATA;
                        len_nxt_s   = '0;
                    end else if (is_idle_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        seq_s = 1'b1;
                    end
                end
                S_DATA: begin
                    // The oversize check wins over terminate/short on the same word.
                    if ((is_data_s || is_term_s) && (len_sum_s > MAX_LEN)) begin
                        err_s       = 1'b1;
                        code_s      = 3'd2;
                        pulse_len_s = len_sum_s;
                        state_nxt_s = S_DROP;
                    end else if (is_data_s) begin
                        len_nxt_s = len_sum_s;
                    end else if (is_term_s) begin
                        state_nxt_s = S_IDLE;
                        pulse_len_s = len_sum_s;
                        if (len_sum_s < MIN_LEN) begin
                            err_s  = 1'b1;
                            code_s = 3'd3;
                        end else begin
                            ok_s = 1'b1;
                        end
                    end else if (is_start_s) begin
                        err_s     = 1'b1;
                        code_s    = 3'd4;
                        len_nxt_s = '0;
                    end else begin
                        // Error characters and idles inside a frame both abort it.
                        err_s       = 1'b1;
                        code_s      = 3'd1;
                        state_nxt_s = S_DROP;
                    end
                end
                S_DROP: begin
                    if (is_term_s || is_idle_s) begin
                        state_nxt_s = S_IDLE;
                    end else if (is_start_s) begin
                        state_nxt_s = S_DATA;
                        len_nxt_s   = '0;
                    end else begin
                        state_nxt_s = S_DROP;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    len_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, length, registered status outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            len_r       <= '0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            seq_err_r   <= 1'b0;
            in_frame_r  <= 1'b0;
            err_code_r  <= 3'd0;
            last_len_r  <= '0;
            ok_cnt_r    <= '0;
            err_cnt_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            len_r       <= len_nxt_s;
            frame_ok_r  <= ok_s;
            frame_err_r <= err_s;
            seq_err_r   <= seq_s;
            in_frame_r  <= (state_nxt_s == S_DATA);
            if (err_s) begin
                err_code_r <= code_s;
            end
            if (ok_s || err_s) begin
                last_len_r <= pulse_len_s;
            end
            if (ok_s && (ok_cnt_r != {CNT_W{1'b1}})) begin
                ok_cnt_r <= ok_cnt_r + CNT_ONE;
            end
            if (err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;
    assign seq_err   = seq_err_r;
    assign in_frame  = in_frame_r;
    assign last_len  = last_len_r;
    assign ok_cnt    = ok_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_mii_frame_checker.sv
// Directed bench for mii_frame_checker: 8-lane default, 8-lane with a small
// MAX_FRAME, and 16-lane instances, each checked against hand-computed values.
module tb_mii_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst8 = 1'b0, valid8 = 1'b0;
    logic [63:0]  data8 = 64'h0;
    logic [7:0]   ctrl8 = 8'h0;
    logic         rst16 = 1'b0, valid16 = 1'b0;
    logic [127:0] data16 = 128'h0;
    logic [15:0]  ctrl16 = 16'h0;

    logic        ok_a, err_a, seq_a, inf_a, ok_b, err_b, seq_b, inf_b, ok_c, err_c, seq_c, inf_c;
    logic [2:0]  code_a, code_b, code_c;
    logic [15:0] len_a, len_b, len_c;
    logic [31:0] okc_a, errc_a, okc_b, errc_b, okc_c, errc_c;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] IDLE8  = 64'h0707070707070707;
    localparam logic [63:0] START8 = 64'h55555555555555FB;
    localparam logic [63:0] DATA8  = 64'h1111111111111111;
    localparam logic [63:0] TERM3  = 64'h07070707FD000000;
    localparam logic [63:0] TERM0  = 64'h07070707070707FD;
    localparam logic [63:0] BAD8   = 64'h000000FE00000000;
    localparam logic [63:0] SEQ8   = 64'h0707070707070706;

    mii_frame_checker #(.NUM_LANES(8)) dut_a (
        .clk(clk), .rst(rst8), .data_in(data8), .ctrl_in(ctrl8), .valid_in(valid8),
        .frame_ok(ok_a), .frame_err(err_a), .err_code(code_a), .seq_err(seq_a),
        .in_frame(inf_a), .last_len(len_a), .ok_cnt(okc_a), .err_cnt(errc_a));

    mii_frame_checker #(.NUM_LANES(8), .MAX_FRAME(128)) dut_b (
        .clk(clk), .rst(rst8), .data_in(data8), .ctrl_in(ctrl8), .valid_in(valid8),
        .frame_ok(ok_b), .frame_err(err_b), .err_code(code_b), .seq_err(seq_b),
        .in_frame(inf_b), .last_len(len_b), .ok_cnt(okc_b), .err_cnt(errc_b));

    mii_frame_checker #(.NUM_LANES(16)) dut_c (
        .clk(clk), .rst(rst16), .data_in(data16), .ctrl_in(ctrl16), .valid_in(valid16),
        .frame_ok(ok_c), .frame_err(err_c), .err_code(code_c), .seq_err(seq_c),
        .in_frame(inf_c), .last_len(len_c), .ok_cnt(okc_c), .err_cnt(errc_c));

    task automatic w8(input logic [63:0] d, input logic [7:0] c, input logic v);
        @(negedge clk);
        data8 = d; ctrl8 = c; valid8 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic w16(input logic [127:0] d, input logic [15:0] c, input logic v);
        @(negedge clk);
        data16 = d; ctrl16 = c; valid16 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        @(negedge clk);
        rst8 = 1'b1; valid8 = 1'b1; data8 = IDLE8; ctrl8 = 8'hFF;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst8 = 1'b0;
    endtask

    task automatic test_reset();
        reset8();
        n_checks++;
        if ({ok_a, err_a, seq_a, inf_a, code_a} !== 7'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000", {ok_a, err_a, seq_a, inf_a, code_a});
        end
        n_checks++;
        if ({len_a, okc_a, errc_a} !== 80'd0) begin
            n_fail++; $display("FAIL reset_counts: got len=%0d ok=%0d err=%0d want 0", len_a, okc_a, errc_a);
        end
    endtask

    task automatic test_good_frame();
        reset8();
        for (int i = 0; i < 10; i++) w8(IDLE8, 8'hFF, 1'b1);
        w8(START8, 8'h01, 1'b1);
        n_checks++;
        if (inf_a !== 1'b1) begin n_fail++; $display("FAIL good_in_frame: got %b want 1", inf_a); end
        for (int i = 0; i < 20; i++) w8(DATA8, 8'h00, 1'b1);
        w8(TERM3, 8'hF8, 1'b1);
        n_checks++;
        if ({ok_a, err_a, inf_a} !== 3'b100) begin
            n_fail++; $display("FAIL good_pulse: got ok/err/in=%b want 100", {ok_a, err_a, inf_a});
        end
        n_checks++;
        if (len_a !== 16'd163) begin n_fail++; $display("FAIL good_len: got %0d want 163", len_a); end
        n_checks++;
        if (okc_a !== 32'd1 || errc_a !== 32'd0) begin
            n_fail++; $display("FAIL good_cnt: got ok=%0d err=%0d want 1 0", okc_a, errc_a);
        end
        w8(IDLE8, 8'hFF, 1'b1);
        n_checks++;
        if (ok_a !== 1'b0) begin n_fail++; $display("FAIL good_one_cycle: got %b want 0", ok_a); end
    endtask

    task automatic test_bad_char();
        reset8();
        w8(START8, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) w8(DATA8, 8'h00, 1'b1);
        w8(BAD8, 8'h10, 1'b1);
        n_checks++;
        if ({err_a, code_a, inf_a} !== 5'b1_001_0) begin
            n_fail++; $display("FAIL bad_pulse: got err/code/in=%b want 10010", {err_a, code_a, inf_a});
        end
        n_checks++;
        if (len_a !== 16'd32) begin n_fail++; $display("FAIL bad_len: got %0d want 32", len_a); end
        for (int i = 0; i < 15; i++) w8(DATA8, 8'h00, 1'b1);
        w8(TERM3, 8'hF8, 1'b1);
        n_checks++;
        if ({ok_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL bad_drop_term: got %b want 00", {ok_a, err_a}); end
        n_checks++;
        if (okc_a !== 32'd0 || errc_a !== 32'd1) begin
            n_fail++; $display("FAIL bad_cnt: got ok=%0d err=%0d want 0 1", okc_a, errc_a);
        end
    endtask

    task automatic test_short();
        reset8();
        w8(START8, 8'h01, 1'b1);
        w8(DATA8, 8'h00, 1'b1);
        w8(DATA8, 8'h00, 1'b1);
        w8(TERM0, 8'hFF, 1'b1);
        n_checks++;
        if ({ok_a, err_a, code_a} !== 5'b0_1_011) begin
            n_fail++; $display("FAIL short_pulse: got ok/err/code=%b want 01011", {ok_a, err_a, code_a});
        end
        n_checks++;
        if (len_a !== 16'd16) begin n_fail++; $display("FAIL short_len: got %0d want 16", len_a); end
    endtask

    task automatic test_too_long();
        reset8();
        n_checks++;
        if (okc_b !== 32'd0 || seq_b !== 1'b0) begin
            n_fail++; $display("FAIL long_reset: got okc=%0d seq=%b want 0 0", okc_b, seq_b);
        end
        w8(START8, 8'h01, 1'b1);
        for (int i = 0; i < 16; i++) w8(DATA8, 8'h00, 1'b1);
        n_checks++;
        if (err_b !== 1'b0 || inf_b !== 1'b1) begin
            n_fail++; $display("FAIL long_at_128: got err=%b in=%b want 0 1", err_b, inf_b);
        end
        w8(DATA8, 8'h00, 1'b1);
        n_checks++;
        if ({err_b, code_b, inf_b} !== 5'b1_010_0) begin
            n_fail++; $display("FAIL long_pulse: got err/code/in=%b want 10100", {err_b, code_b, inf_b});
        end
        n_checks++;
        if (len_b !== 16'd136) begin n_fail++; $display("FAIL long_len: got %0d want 136", len_b); end
        for (int i = 0; i < 3; i++) w8(DATA8, 8'h00, 1'b1);
        w8(TERM3, 8'hF8, 1'b1);
        n_checks++;
        if ({ok_b, err_b} !== 2'b00 || errc_b !== 32'd1) begin
            n_fail++; $display("FAIL long_term_silent: got ok/err=%b errc=%0d want 00 1", {ok_b, err_b}, errc_b);
        end
    endtask

    task automatic test_back_to_back();
        reset8();
        w8(START8, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++) w8(DATA8, 8'h00, 1'b1);
        w8(START8, 8'h01, 1'b1);
        n_checks++;
        if ({err_a, code_a, inf_a} !== 5'b1_100_1) begin
            n_fail++; $display("FAIL restart_pulse: got err/code/in=%b want 11001", {err_a, code_a, inf_a});
        end
        n_checks++;
        if (len_a !== 16'd80) begin n_fail++; $display("FAIL restart_len: got %0d want 80", len_a); end
        for (int i = 0; i < 10; i++) w8(DATA8, 8'h00, 1'b1);
        w8(TERM3, 8'hF8, 1'b1);
        n_checks++;
        if (ok_a !== 1'b1 || len_a !== 16'd83) begin
            n_fail++; $display("FAIL restart_ok: got ok=%b len=%0d want 1 83", ok_a, len_a);
        end
        n_checks++;
        if (okc_a !== 32'd1 || errc_a !== 32'd1) begin
            n_fail++; $display("FAIL restart_cnt: got ok=%0d err=%0d want 1 1", okc_a, errc_a);
        end
    endtask

    task automatic test_seq_err();
        reset8();
        w8(IDLE8, 8'hFF, 1'b1);
        w8(SEQ8, 8'hFF, 1'b1);
        n_checks++;
        if (seq_a !== 1'b1 || inf_a !== 1'b0) begin
            n_fail++; $display("FAIL seq_pulse: got seq=%b in=%b want 1 0", seq_a, inf_a);
        end
        w8(IDLE8, 8'hFF, 1'b1);
        n_checks++;
        if (seq_a !== 1'b0) begin n_fail++; $display("FAIL seq_one_cycle: got %b want 0", seq_a); end
    endtask

    task automatic test_valid_gap16();
        @(negedge clk); rst16 = 1'b1; valid16 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst16 = 1'b0;
        w16({120'h555555555555555555555555555555, 8'hFB}, 16'h0001, 1'b1);
        w16({8'hFD, 120'h0}, 16'h8000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w16({16{8'h22}}, 16'h0000, 1'b1);
            w16({{15{8'h07}}, 8'hFE}, 16'hFFFF, 1'b0);
            n_checks++;
            if ({ok_c, err_c, seq_c, inf_c} !== 4'b0001) begin
                n_fail++; $display("FAIL gap_hold%0d: got ok/err/seq/in=%b want 0001", i, {ok_c, err_c, seq_c, inf_c});
            end
        end
        w16({8'hFD, 120'h0}, 16'h8000, 1'b1);
        n_checks++;
        if (ok_c !== 1'b1 || len_c !== 16'd95) begin
            n_fail++; $display("FAIL gap_term15: got ok=%b len=%0d want 1 95", ok_c, len_c);
        end
        w16({8'hFD, 120'h0}, 16'h8000, 1'b0);
        n_checks++;
        if (ok_c !== 1'b0 || okc_c !== 32'd1) begin
            n_fail++; $display("FAIL gap_after: got ok=%b okc=%0d want 0 1", ok_c, okc_c);
        end
        w16({{15{8'h07}}, 8'h07}, 16'hFFFF, 1'b1);
        w16({64'h0707070707070707, SEQ8}, 16'hFFFF, 1'b1);
        n_checks++;
        if (seq_c !== 1'b1) begin n_fail++; $display("FAIL seq16_pulse: got %b want 1", seq_c); end
    endtask

    task automatic test_mid_reset16();
        w16({120'h555555555555555555555555555555, 8'hFB}, 16'h0001, 1'b1);
        for (int i = 0; i < 3; i++) w16({16{8'h33}}, 16'h0000, 1'b1);
        @(negedge clk);
        rst16 = 1'b1; data16 = {8'hFD, 120'h0}; ctrl16 = 16'h8000; valid16 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ok_c, err_c, seq_c, inf_c, code_c} !== 7'd0 || {len_c, okc_c, errc_c} !== 80'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got flags=%b len=%0d okc=%0d errc=%0d want 0",
                               {ok_c, err_c, seq_c, inf_c, code_c}, len_c, okc_c, errc_c);
        end
        @(negedge clk); rst16 = 1'b0;
        w16({16{8'h07}}, 16'hFFFF, 1'b1);
        n_checks++;
        if ({ok_c, err_c, seq_c, inf_c} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_after: got ok/err/seq/in=%b want 0000", {ok_c, err_c, seq_c, inf_c});
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_char();
        test_short();
        test_too_long();
        test_back_to_back();
        test_seq_err();
        test_valid_gap16();
        test_mid_reset16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
